// File: rtl/ind_heard_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ind_heard_arbiter
//  Purpose  : Round-robin arbiter sharing one downstream `heard` indication
//             port between NREQ requesters, with a one-entry output buffer
//             that drains and reloads in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module ind_heard_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int SRCW  = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NREQ-1:0]       req_pending,
    output logic [NREQ-1:0]       req__RDY,
    input  logic [NREQ-1:0]       req__ENA,
    input  logic [NREQ*WIDTH-1:0] req_v,
    output logic                  out__ENA,
    output logic [WIDTH-1:0]      out_v,
    output logic [SRCW-1:0]       out_src,
    input  logic                  out__RDY,
    output logic                  protocol_err,
    output logic [15:0]           xfer_count
);

    logic             r_full;
    logic [WIDTH-1:0] r_buf_v;
    logic [SRCW-1:0]  r_buf_src;
    logic [SRCW-1:0]  r_ptr;
    logic             r_protocol_err;
    logic [15:0]      r_xfer_count;

    logic             w_drain;
    logic             w_space;
    logic             w_any;
    logic [SRCW-1:0]  w_sel;
    logic [SRCW-1:0]  w_ptr_next;
    logic [NREQ-1:0]  w_grant;
    logic             w_accept;
    logic             w_err;
    logic [WIDTH-1:0] w_slices [NREQ];

    // Unpack the flat payload bus into one word per requester.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_slices[gi] = req_v[gi*WIDTH +: WIDTH];
    end

    assign w_drain = r_full & out__RDY;
    assign w_space = ~r_full | out__RDY;
    assign w_any   = |req_pending;

    // Pick the first pending requester scanning from r_ptr; iterating from the
    // far end backwards lets the nearest pending index overwrite the others.
    always_comb begin
        w_sel = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_pending[SRCW'((int'(r_ptr) + k) % NREQ)]) begin
                w_sel = SRCW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    // Grant depends only on pending/space/reset, never on ENA or payload,
    // so the requester's enable cannot loop back into its own ready.
    assign w_grant    = (nRST && w_space && w_any) ? (NREQ'(1) << w_sel) : '0;
    assign w_accept   = |(req__ENA & w_grant);
    assign w_err      = |(req__ENA & ~w_grant);
    assign w_ptr_next = (int'(w_sel) == NREQ - 1) ? '0 : w_sel + SRCW'(1);

    // Buffer, round-robin pointer, sticky error and transfer counter.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_full         <= 1'b0;
            r_buf_v        <= '0;
            r_buf_src      <= '0;
            r_ptr          <= '0;
            r_protocol_err <= 1'b0;
            r_xfer_count   <= '0;
        end else begin
            if (w_accept) begin
                r_full    <= 1'b1;
                r_buf_v   <= w_slices[w_sel];
                r_buf_src <= w_sel;
                r_ptr     <= w_ptr_next;
            end else if (w_drain) begin
                r_full <= 1'b0;
            end
            if (w_drain) begin
                r_xfer_count <= r_xfer_count + 16'd1;
            end
            if (w_err) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    assign req__RDY     = w_grant;
    assign out__ENA     = r_full;
    assign out_v        = r_buf_v;
    assign out_src      = r_buf_src;
    assign protocol_err = r_protocol_err;
    assign xfer_count   = r_xfer_count;

endmodule
`default_nettype wire

// File: tb/tb_ind_heard_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ind_heard_arbiter
//  Purpose  : Directed table-driven bench for ind_heard_arbiter, plus reset
//             mid-operation and 65536-transfer counter-wrap sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ind_heard_arbiter;

    logic          CLK;
    logic          nRST;
    logic [3:0]    req_pending;
    logic [3:0]    req__RDY;
    logic [3:0]    req__ENA;
    logic [127:0]  req_v;
    logic          out__ENA;
    logic [31:0]   out_v;
    logic [1:0]    out_src;
    logic          out__RDY;
    logic          protocol_err;
    logic [15:0]   xfer_count;

    int tests;
    int fails;

    ind_heard_arbiter #(.NREQ(4), .WIDTH(32), .SRCW(2)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .req_pending  (req_pending),
        .req__RDY     (req__RDY),
        .req__ENA     (req__ENA),
        .req_v        (req_v),
        .out__ENA     (out__ENA),
        .out_v        (out_v),
        .out_src      (out_src),
        .out__RDY     (out__RDY),
        .protocol_err (protocol_err),
        .xfer_count   (xfer_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]   pend;
        logic [3:0]   ena;
        logic [127:0] vals;
        logic         ordy;
        logic [3:0]   e_rdy;
        logic         e_oena;
        logic [31:0]  e_v;
        logic [1:0]   e_src;
        logic         e_err;
        logic [15:0]  e_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] v;
        logic [1:0]  src;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];

    function automatic logic [127:0] sv4(input logic [31:0] v0, input logic [31:0] v1,
                                         input logic [31:0] v2, input logic [31:0] v3);
        return {v3, v2, v1, v0};
    endfunction

    function automatic vec_t mk(input logic [3:0] pend, input logic [3:0] ena,
                                input logic [127:0] vals, input logic ordy,
                                input logic [3:0] e_rdy, input logic e_oena,
                                input logic [31:0] e_v, input logic [1:0] e_src,
                                input logic e_err, input logic [15:0] e_cnt);
        vec_t r;
        r.pend = pend; r.ena = ena; r.vals = vals; r.ordy = ordy;
        r.e_rdy = e_rdy; r.e_oena = e_oena; r.e_v = e_v; r.e_src = e_src;
        r.e_err = e_err; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [127:0] rr;
        logic [3:0]   oh;
        int           mptr;
        int           bad;
        sb_t          e;

        tests = 0;
        fails = 0;

        // Reset held for two edges with everyone pending.
        nRST = 1'b0; req_pending = 4'hF; req__ENA = 4'h0; req_v = '0; out__RDY = 1'b1;
        @(negedge CLK); #1;
        chk("rst_rdy0", 32'(req__RDY), 32'h0);
        chk("rst_ena0", 32'(out__ENA), 32'h0);
        @(negedge CLK); #1;
        chk("rst_rdy1", 32'(req__RDY), 32'h0);
        chk("rst_ena1", 32'(out__ENA), 32'h0);
        nRST = 1'b1;

        rr = sv4(32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003);
        // idle after reset
        tbl.push_back(mk(4'h0, 4'h0, '0, 1'b1, 4'h0, 1'b0, 32'h0, 2'd0, 1'b0, 16'd0));
        // round robin 0,1,2,3,0,1 with no idle cycles
        tbl.push_back(mk(4'hF, 4'h1, rr, 1'b1, 4'h1, 1'b0, 32'h0,        2'd0, 1'b0, 16'd0));
        tbl.push_back(mk(4'hF, 4'h2, rr, 1'b1, 4'h2, 1'b1, 32'h10000000, 2'd0, 1'b0, 16'd0));
        tbl.push_back(mk(4'hF, 4'h4, rr, 1'b1, 4'h4, 1'b1, 32'h10000001, 2'd1, 1'b0, 16'd1));
        tbl.push_back(mk(4'hF, 4'h8, rr, 1'b1, 4'h8, 1'b1, 32'h10000002, 2'd2, 1'b0, 16'd2));
        tbl.push_back(mk(4'hF, 4'h1, rr, 1'b1, 4'h1, 1'b1, 32'h10000003, 2'd3, 1'b0, 16'd3));
        tbl.push_back(mk(4'hF, 4'h2, rr, 1'b1, 4'h2, 1'b1, 32'h10000000, 2'd0, 1'b0, 16'd4));
        tbl.push_back(mk(4'h0, 4'h0, rr, 1'b1, 4'h0, 1'b1, 32'h10000001, 2'd1, 1'b0, 16'd5));
        // single requester 2, then pointer lands on 3
        tbl.push_back(mk(4'h4, 4'h4, sv4(0, 0, 32'hDEADBEEF, 0), 1'b1, 4'h4, 1'b0, 32'h10000001, 2'd1, 1'b0, 16'd6));
        tbl.push_back(mk(4'h0, 4'h0, '0, 1'b1, 4'h0, 1'b1, 32'hDEADBEEF, 2'd2, 1'b0, 16'd6));
        tbl.push_back(mk(4'hF, 4'h0, '0, 1'b1, 4'h8, 1'b0, 32'hDEADBEEF, 2'd2, 1'b0, 16'd7));
        // backpressure: load 0x11, stall five cycles, then drain+load 0x22
        tbl.push_back(mk(4'h8, 4'h8, sv4(0, 0, 0, 32'h11), 1'b0, 4'h8, 1'b0, 32'hDEADBEEF, 2'd2, 1'b0, 16'd7));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(4'h2, 4'h0, sv4(0, 32'h22, 0, 0), 1'b0, 4'h0, 1'b1, 32'h11, 2'd3, 1'b0, 16'd7));
        tbl.push_back(mk(4'h2, 4'h2, sv4(0, 32'h22, 0, 0), 1'b1, 4'h2, 1'b1, 32'h11, 2'd3, 1'b0, 16'd7));
        tbl.push_back(mk(4'h0, 4'h0, '0, 1'b0, 4'h0, 1'b1, 32'h22, 2'd1, 1'b0, 16'd8));
        tbl.push_back(mk(4'h0, 4'h0, '0, 1'b1, 4'h0, 1'b1, 32'h22, 2'd1, 1'b0, 16'd8));
        // protocol error: ENA[3] without grant, no load, ptr stays at 2
        tbl.push_back(mk(4'h4, 4'h8, sv4(0, 0, 0, 32'h55), 1'b1, 4'h4, 1'b0, 32'h22, 2'd1, 1'b0, 16'd9));
        tbl.push_back(mk(4'hF, 4'h0, '0, 1'b1, 4'h4, 1'b0, 32'h22, 2'd1, 1'b1, 16'd9));
        // multiple ENA bits: only granted requester 2 loads
        tbl.push_back(mk(4'hF, 4'h6, sv4(0, 32'h66, 32'h77, 0), 1'b1, 4'h4, 1'b0, 32'h22, 2'd1, 1'b1, 16'd9));
        tbl.push_back(mk(4'h0, 4'h0, '0, 1'b1, 4'h0, 1'b1, 32'h77, 2'd2, 1'b1, 16'd9));

        foreach (tbl[i]) begin
            req_pending = tbl[i].pend;
            req__ENA    = tbl[i].ena;
            req_v       = tbl[i].vals;
            out__RDY    = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d_rdy", i), 32'(req__RDY),     32'(tbl[i].e_rdy));
            chk($sformatf("v%0d_ena", i), 32'(out__ENA),     32'(tbl[i].e_oena));
            chk($sformatf("v%0d_val", i), out_v,             tbl[i].e_v);
            chk($sformatf("v%0d_src", i), 32'(out_src),      32'(tbl[i].e_src));
            chk($sformatf("v%0d_err", i), 32'(protocol_err), 32'(tbl[i].e_err));
            chk($sformatf("v%0d_cnt", i), 32'(xfer_count),   32'(tbl[i].e_cnt));
            @(negedge CLK);
        end

        // Reset mid-operation: buffered 0x99 is discarded, ptr back to 0.
        req_pending = 4'h1; req__ENA = 4'h1; req_v = sv4(32'h99, 0, 0, 0); out__RDY = 1'b0;
        #1;
        chk("mid_rdy", 32'(req__RDY), 32'h1);
        @(negedge CLK);
        req__ENA = 4'h0; req_pending = 4'hF;
        #1;
        chk("mid_full", 32'(out__ENA), 32'h1);
        chk("mid_val", out_v, 32'h99);
        nRST = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(req__RDY), 32'h0);
        @(negedge CLK);
        nRST = 1'b1; out__RDY = 1'b1;
        #1;
        chk("post_ena", 32'(out__ENA), 32'h0);
        chk("post_val", out_v, 32'h0);
        chk("post_src", 32'(out_src), 32'h0);
        chk("post_err", 32'(protocol_err), 32'h0);
        chk("post_cnt", 32'(xfer_count), 32'h0);
        chk("post_rdy", 32'(req__RDY), 32'h1);
        req_pending = 4'h0;
        @(negedge CLK);

        // 65536 back-to-back transfers with a payload/source scoreboard.
        mptr = 0;
        bad  = 0;
        for (int k = 0; k <= 65536; k++) begin
            oh = 4'b0001 << mptr;
            if (k < 65536) begin
                req_pending = 4'hF;
                req__ENA    = oh;
                req_v       = {4{32'(k)}};
            end else begin
                req_pending = 4'h0;
                req__ENA    = 4'h0;
            end
            #1;
            if (k < 65536 && req__RDY !== oh) bad++;
            if (out__ENA !== (k > 0)) bad++;
            if (out__ENA === 1'b1) begin
                if (sbq.size() == 0) begin
                    bad++;
                end else begin
                    e = sbq.pop_front();
                    if (out_v !== e.v || out_src !== e.src) bad++;
                end
            end
            if (k < 65536) begin
                e.v   = 32'(k);
                e.src = 2'(mptr);
                sbq.push_back(e);
                mptr  = (mptr + 1) % 4;
            end
            @(negedge CLK);
        end
        #1;
        chk("wrap_mismatches", 32'(bad), 32'h0);
        chk("wrap_sb_left", 32'(sbq.size()), 32'h0);
        chk("wrap_cnt", 32'(xfer_count), 32'h0);
        chk("wrap_ena", 32'(out__ENA), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
